// File: rtl/memory_stage.sv
// memory_stage: data-memory and stack access stage between EX/MEM and MEM/WB.
// 32-bit PC pushes/pops and flag saves are serialised into 16-bit word transfers.
module memory_stage #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Data,
    input  logic [31:0] Address,
    input  logic        MR,
    input  logic        MW,
    input  logic        WB,
    input  logic [2:0]  WB_Address,
    input  logic        Stack_PC,
    input  logic        Stack_Flags,
    input  logic [2:0]  Final_Flags,
    output logic        Stall,
    output logic [15:0] WB_Data,
    output logic        WB_Out,
    output logic [2:0]  WB_Address_Out,
    output logic [31:0] PC_From_Stack,
    output logic        PC_Load,
    output logic [2:0]  Flags_From_Memory,
    output logic        Flags_Load
);
    typedef enum logic {IDLE, XFER} state_t;
    typedef enum logic [1:0] {ROLE_DATA, ROLE_FLAGS, ROLE_PC_HI, ROLE_PC_LO} role_t;

    state_t                state_q, state_d;
    logic [1:0]            idx_q, idx_d;

    logic [31:0]           data_p0;
    logic [ADDR_WIDTH-1:0] addr_p0;
    logic                  mr_p0, mw_p0, wb_p0, spc_p0, sfl_p0;
    logic [2:0]            wba_p0, ff_p0;
    logic [31:0]           pc_buf_p0;

    logic [15:0]           mem [0:(1<<ADDR_WIDTH)-1];

    logic [31:0]           sel_data;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_mr, sel_mw, sel_wb, sel_spc, sel_sfl;
    logic [2:0]            sel_wba, sel_ff;
    logic [1:0]            idx;
    logic                  cur_rd, cur_wr, req, last;
    logic [1:0]            n_words;
    role_t                 role;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [15:0]           wr_word, rd_word;
    logic [31:0]           pc_next;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^Address[31:ADDR_WIDTH];

    // Push order runs flags, PC high, PC low downward; pops mirror it upward.
    function automatic role_t word_role(input logic rd, input logic spc,
                                        input logic sfl, input logic [1:0] k);
        role_t r;
        r = ROLE_DATA;
        if (spc && sfl) begin
            case (k)
                2'd0:    r = rd ? ROLE_PC_LO : ROLE_FLAGS;
                2'd1:    r = ROLE_PC_HI;
                default: r = rd ? ROLE_FLAGS : ROLE_PC_LO;
            endcase
        end else if (spc) begin
            r = ((k == 2'd0) == rd) ? ROLE_PC_LO : ROLE_PC_HI;
        end else if (sfl) begin
            r = ROLE_FLAGS;
        end
        return r;
    endfunction

    // While transferring, work only from the latched copy of the request.
    always_comb begin
        if (state_q == XFER) begin
            sel_data = data_p0;  sel_addr = addr_p0;
            sel_mr   = mr_p0;    sel_mw   = mw_p0;   sel_wb  = wb_p0;
            sel_spc  = spc_p0;   sel_sfl  = sfl_p0;
            sel_wba  = wba_p0;   sel_ff   = ff_p0;
            idx      = idx_q;
        end else begin
            sel_data = Data;     sel_addr = Address[ADDR_WIDTH-1:0];
            sel_mr   = MR;       sel_mw   = MW;      sel_wb  = WB;
            sel_spc  = Stack_PC; sel_sfl  = Stack_Flags;
            sel_wba  = WB_Address; sel_ff = Final_Flags;
            idx      = 2'd0;
        end
    end

    always_comb begin
        cur_wr  = sel_mw;
        cur_rd  = sel_mr & ~sel_mw;
        req     = sel_mr | sel_mw | sel_wb;
        n_words = 2'd1;
        if ((cur_rd | cur_wr) && sel_spc)
            n_words = sel_sfl ? 2'd3 : 2'd2;
        last  = (idx == n_words - 2'd1);
        Stall = req & ~last;
        role  = word_role(cur_rd, sel_spc, sel_sfl, idx);
        word_addr = cur_wr ? sel_addr - ADDR_WIDTH'(idx) : sel_addr + ADDR_WIDTH'(idx);
        case (role)
            ROLE_FLAGS: wr_word = {13'b0, sel_ff};
            ROLE_PC_HI: wr_word = sel_data[31:16];
            default:    wr_word = sel_data[15:0];
        endcase
        rd_word = mem[word_addr];
        pc_next = pc_buf_p0;
        if (cur_rd && role == ROLE_PC_LO) pc_next[15:0]  = rd_word;
        if (cur_rd && role == ROLE_PC_HI) pc_next[31:16] = rd_word;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == IDLE) begin
            if (req && !last) begin
                state_d = XFER;
                idx_d   = 2'd1;
            end
        end else if (last) begin
            state_d = IDLE;
            idx_d   = 2'd0;
        end else begin
            idx_d = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            idx_q             <= 2'd0;
            WB_Out            <= 1'b0;
            WB_Data           <= 16'd0;
            WB_Address_Out    <= 3'd0;
            PC_From_Stack     <= 32'd0;
            PC_Load           <= 1'b0;
            Flags_From_Memory <= 3'd0;
            Flags_Load        <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            WB_Out     <= req & last & sel_wb;
            PC_Load    <= req & last & cur_rd & sel_spc;
            Flags_Load <= req & last & cur_rd & sel_sfl;
            if (req && last && (cur_rd || sel_wb)) begin
                WB_Data        <= cur_rd ? rd_word : sel_data[15:0];
                WB_Address_Out <= sel_wba;
            end
            if (req && last && cur_rd && sel_spc) PC_From_Stack <= pc_next;
            if (req && last && cur_rd && sel_sfl) Flags_From_Memory <= rd_word[2:0];
        end
    end

    // Request copy and PC assembly buffer: datapath only, no reset needed.
    always_ff @(posedge clk) begin
        pc_buf_p0 <= pc_next;
        if (state_q == IDLE && state_d == XFER) begin
            data_p0 <= Data;        addr_p0 <= Address[ADDR_WIDTH-1:0];
            mr_p0   <= MR;          mw_p0   <= MW;        wb_p0 <= WB;
            spc_p0  <= Stack_PC;    sfl_p0  <= Stack_Flags;
            wba_p0  <= WB_Address;  ff_p0   <= Final_Flags;
        end
    end

    always_ff @(posedge clk) begin
        if (cur_wr && !reset) mem[word_addr] <= wr_word;
    end
endmodule

// File: tb/tb_memory_stage.sv
// Directed testbench for memory_stage: plain access, stack push/pop, wrap, reset abort.
module tb_memory_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Data, Address;
    logic        MR, MW, WB, Stack_PC, Stack_Flags;
    logic [2:0]  WB_Address, Final_Flags;
    logic        Stall, WB_Out, PC_Load, Flags_Load;
    logic [15:0] WB_Data;
    logic [2:0]  WB_Address_Out, Flags_From_Memory;
    logic [31:0] PC_From_Stack;

    int n_tests = 0;
    int n_fail  = 0;

    memory_stage #(.ADDR_WIDTH(12)) dut (
        .clk(clk), .reset(reset), .Data(Data), .Address(Address),
        .MR(MR), .MW(MW), .WB(WB), .WB_Address(WB_Address),
        .Stack_PC(Stack_PC), .Stack_Flags(Stack_Flags), .Final_Flags(Final_Flags),
        .Stall(Stall), .WB_Data(WB_Data), .WB_Out(WB_Out),
        .WB_Address_Out(WB_Address_Out), .PC_From_Stack(PC_From_Stack),
        .PC_Load(PC_Load), .Flags_From_Memory(Flags_From_Memory),
        .Flags_Load(Flags_Load)
    );

    always #5 clk = ~clk;

    task automatic set_idle();
        Data = 32'd0; Address = 32'd0; MR = 1'b0; MW = 1'b0; WB = 1'b0;
        WB_Address = 3'd0; Stack_PC = 1'b0; Stack_Flags = 1'b0; Final_Flags = 3'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mr, input logic mw, input logic wb, input logic [2:0] wba,
                         input logic spc, input logic sfl, input logic [31:0] addr,
                         input logic [31:0] dat, input logic [2:0] ff);
        MR = mr; MW = mw; WB = wb; WB_Address = wba; Stack_PC = spc; Stack_Flags = sfl;
        Address = addr; Data = dat; Final_Flags = ff;
    endtask

    task automatic read_word(input logic [31:0] addr, output logic [15:0] d);
        drive(1, 0, 1, 3'd0, 0, 0, addr, 32'd0, 3'd0);
        step();
        d = WB_Data;
        set_idle();
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        #1;
        n_tests++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", Stall); end
        n_tests++; if (WB_Out !== 1'b0 || WB_Data !== 16'd0 || WB_Address_Out !== 3'd0) begin
            n_fail++; $display("FAIL reset_wb got out=%b data=%h addr=%0d want 0", WB_Out, WB_Data, WB_Address_Out); end
        n_tests++; if (PC_Load !== 1'b0 || PC_From_Stack !== 32'd0 || Flags_Load !== 1'b0 || Flags_From_Memory !== 3'd0) begin
            n_fail++; $display("FAIL reset_stack got pcl=%b pc=%h fl=%b f=%b want 0", PC_Load, PC_From_Stack, Flags_Load, Flags_From_Memory); end
        step();
    endtask

    task automatic test_plain();
        logic [15:0] d;
        drive(0, 1, 0, 3'd0, 0, 0, 32'h010, 32'h0000ABCD, 3'd0);
        #2;
        n_tests++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL plain_mw_stall got %b want 0", Stall); end
        step();
        drive(1, 0, 1, 3'd3, 0, 0, 32'h010, 32'd0, 3'd0);
        #2;
        n_tests++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL plain_mr_stall got %b want 0", Stall); end
        step();
        set_idle();
        n_tests++; if (WB_Out !== 1'b1 || WB_Data !== 16'hABCD || WB_Address_Out !== 3'd3) begin
            n_fail++; $display("FAIL plain_read got out=%b data=%h addr=%0d want 1 abcd 3", WB_Out, WB_Data, WB_Address_Out); end
        step();
        n_tests++; if (WB_Out !== 1'b0 || WB_Data !== 16'hABCD) begin
            n_fail++; $display("FAIL idle_hold got out=%b data=%h want 0 abcd", WB_Out, WB_Data); end
        drive(0, 0, 1, 3'd5, 0, 0, 32'h0, 32'h00001234, 3'd0);
        step();
        set_idle();
        n_tests++; if (WB_Out !== 1'b1 || WB_Data !== 16'h1234 || WB_Address_Out !== 3'd5) begin
            n_fail++; $display("FAIL wb_only got out=%b data=%h addr=%0d want 1 1234 5", WB_Out, WB_Data, WB_Address_Out); end
        drive(1, 1, 1, 3'd2, 0, 0, 32'h020, 32'h00005A5A, 3'd0);
        step();
        set_idle();
        n_tests++; if (WB_Data !== 16'h5A5A) begin n_fail++; $display("FAIL mr_mw_wbdata got %h want 5a5a", WB_Data); end
        read_word(32'h020, d);
        n_tests++; if (d !== 16'h5A5A) begin n_fail++; $display("FAIL mr_mw_mem got %h want 5a5a", d); end
    endtask

    task automatic test_push_pop_pc();
        logic [15:0] d;
        drive(0, 1, 0, 3'd0, 1, 0, 32'h3FF, 32'h00120034, 3'd0);
        #2;
        n_tests++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL push_stall0 got %b want 1", Stall); end
        step();
        set_idle();
        #1;
        n_tests++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL push_stall1 got %b want 0", Stall); end
        step();
        n_tests++; if (PC_Load !== 1'b0 || WB_Out !== 1'b0) begin
            n_fail++; $display("FAIL push_pulses got pcl=%b wb=%b want 0 0", PC_Load, WB_Out); end
        read_word(32'h3FF, d);
        n_tests++; if (d !== 16'h0012) begin n_fail++; $display("FAIL push_hi got %h want 0012", d); end
        read_word(32'h3FE, d);
        n_tests++; if (d !== 16'h0034) begin n_fail++; $display("FAIL push_lo got %h want 0034", d); end
        drive(1, 0, 0, 3'd0, 1, 0, 32'h3FE, 32'd0, 3'd0);
        #2;
        n_tests++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL pop_stall0 got %b want 1", Stall); end
        step();
        set_idle();
        #1;
        n_tests++; if (Stall !== 1'b0 || PC_Load !== 1'b0) begin
            n_fail++; $display("FAIL pop_word1 got stall=%b pcl=%b want 0 0", Stall, PC_Load); end
        step();
        n_tests++; if (PC_Load !== 1'b1 || PC_From_Stack !== 32'h00120034 || Flags_Load !== 1'b0) begin
            n_fail++; $display("FAIL pop_load got pcl=%b pc=%h fl=%b want 1 00120034 0", PC_Load, PC_From_Stack, Flags_Load); end
        step();
        n_tests++; if (PC_Load !== 1'b0) begin n_fail++; $display("FAIL pop_pulse_end got %b want 0", PC_Load); end
    endtask

    task automatic test_interrupt();
        logic [15:0] d;
        drive(0, 1, 0, 3'd0, 1, 1, 32'h100, 32'h0000000F, 3'b101);
        #2;
        n_tests++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL int_stall0 got %b want 1", Stall); end
        step();
        set_idle();
        #1;
        n_tests++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL int_stall1 got %b want 1", Stall); end
        step();
        n_tests++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL int_stall2 got %b want 0", Stall); end
        step();
        read_word(32'h100, d);
        n_tests++; if (d !== 16'h0005) begin n_fail++; $display("FAIL int_flags got %h want 0005", d); end
        read_word(32'h0FF, d);
        n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL int_pchi got %h want 0000", d); end
        read_word(32'h0FE, d);
        n_tests++; if (d !== 16'h000F) begin n_fail++; $display("FAIL int_pclo got %h want 000f", d); end
        drive(1, 0, 0, 3'd0, 1, 1, 32'h0FE, 32'd0, 3'd0);
        step();
        set_idle();
        step();
        n_tests++; if (PC_Load !== 1'b0 || Flags_Load !== 1'b0) begin
            n_fail++; $display("FAIL rti_early got pcl=%b fl=%b want 0 0", PC_Load, Flags_Load); end
        step();
        n_tests++; if (PC_Load !== 1'b1 || Flags_Load !== 1'b1 || PC_From_Stack !== 32'h0000000F || Flags_From_Memory !== 3'b101) begin
            n_fail++; $display("FAIL rti_load got pcl=%b fl=%b pc=%h f=%b want 1 1 0000000f 101", PC_Load, Flags_Load, PC_From_Stack, Flags_From_Memory); end
        step();
        n_tests++; if (PC_Load !== 1'b0 || Flags_Load !== 1'b0) begin
            n_fail++; $display("FAIL rti_pulse_end got pcl=%b fl=%b want 0 0", PC_Load, Flags_Load); end
    endtask

    task automatic test_wrap();
        logic [15:0] d;
        drive(0, 1, 0, 3'd0, 1, 0, 32'h000, 32'hAAAA5555, 3'd0);
        step();
        set_idle();
        step();
        read_word(32'h000, d);
        n_tests++; if (d !== 16'hAAAA) begin n_fail++; $display("FAIL wrap_hi got %h want aaaa", d); end
        read_word(32'hFFF, d);
        n_tests++; if (d !== 16'h5555) begin n_fail++; $display("FAIL wrap_lo got %h want 5555", d); end
        drive(1, 0, 0, 3'd0, 1, 0, 32'hFFF, 32'd0, 3'd0);
        step();
        set_idle();
        step();
        n_tests++; if (PC_Load !== 1'b1 || PC_From_Stack !== 32'hAAAA5555) begin
            n_fail++; $display("FAIL wrap_pop got pcl=%b pc=%h want 1 aaaa5555", PC_Load, PC_From_Stack); end
    endtask

    task automatic test_flags_only();
        logic [15:0] d;
        drive(0, 1, 0, 3'd0, 0, 1, 32'h200, 32'd0, 3'b011);
        #2;
        n_tests++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL fpush_stall got %b want 0", Stall); end
        step();
        set_idle();
        read_word(32'h200, d);
        n_tests++; if (d !== 16'h0003) begin n_fail++; $display("FAIL fpush_mem got %h want 0003", d); end
        drive(1, 0, 0, 3'd0, 0, 1, 32'h200, 32'd0, 3'd0);
        step();
        set_idle();
        n_tests++; if (Flags_Load !== 1'b1 || Flags_From_Memory !== 3'b011 || PC_Load !== 1'b0) begin
            n_fail++; $display("FAIL fpop got fl=%b f=%b pcl=%b want 1 011 0", Flags_Load, Flags_From_Memory, PC_Load); end
    endtask

    task automatic test_reset_mid_xfer();
        logic [15:0] d;
        drive(0, 1, 0, 3'd0, 0, 0, 32'h2FF, 32'h00001111, 3'd0);
        step();
        drive(0, 1, 0, 3'd0, 0, 0, 32'h2FE, 32'h00002222, 3'd0);
        step();
        drive(0, 1, 1, 3'd6, 1, 1, 32'h300, 32'hBEEFCAFE, 3'b111);
        step();
        set_idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        n_tests++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL abort_stall got %b want 0", Stall); end
        n_tests++; if (WB_Out !== 1'b0 || WB_Data !== 16'd0 || PC_Load !== 1'b0 || Flags_Load !== 1'b0 || PC_From_Stack !== 32'd0) begin
            n_fail++; $display("FAIL abort_outputs got wb=%b d=%h pcl=%b fl=%b pc=%h want 0", WB_Out, WB_Data, PC_Load, Flags_Load, PC_From_Stack); end
        step();
        n_tests++; if (WB_Out !== 1'b0 || PC_Load !== 1'b0 || Flags_Load !== 1'b0) begin
            n_fail++; $display("FAIL abort_late got wb=%b pcl=%b fl=%b want 0", WB_Out, PC_Load, Flags_Load); end
        read_word(32'h300, d);
        n_tests++; if (d !== 16'h0007) begin n_fail++; $display("FAIL abort_word0 got %h want 0007", d); end
        read_word(32'h2FF, d);
        n_tests++; if (d !== 16'h1111) begin n_fail++; $display("FAIL abort_word1 got %h want 1111", d); end
        read_word(32'h2FE, d);
        n_tests++; if (d !== 16'h2222) begin n_fail++; $display("FAIL abort_word2 got %h want 2222", d); end
    endtask

    initial begin
        set_idle();
        reset = 1'b1;
        #1;
        test_reset();
        test_plain();
        test_push_pop_pc();
        test_interrupt();
        test_wrap();
        test_flags_only();
        test_reset_mid_xfer();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
